// File: rtl/parallel_crc_engine.sv
// parallel_crc_engine: folds PAR message bits per beat into a CRC and holds the result until consumed.
// Optional crc_ok output (pre-XOR_OUT register is zero) is enabled by defining PARALLEL_CRC_CHECK_EN.
module parallel_crc_engine #(
    parameter int                CRC_W   = 8,
    parameter logic [CRC_W-1:0]  POLY    = 8'h07,
    parameter int                PAR     = 3,
    parameter logic [CRC_W-1:0]  INIT    = '0,
    parameter logic [CRC_W-1:0]  XOR_OUT = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PAR-1:0]             in_data,
    input  logic                       in_last,
    input  logic [$clog2(PAR+1)-1:0]   in_nvalid,
    output logic                       crc_valid,
    output logic [CRC_W-1:0]           crc_out,
    input  logic                       out_ready,
`ifdef PARALLEL_CRC_CHECK_EN
    output logic                       crc_ok,
`endif
    output logic                       busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
    state_e           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d, fold;
    logic             accept;
    int               n;
    assign accept    = in_valid & in_ready;
    assign in_ready  = reset & (state_q != DONE);
    assign crc_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign crc_out   = crc_valid ? crc_q ^ XOR_OUT : '0;
`ifdef PARALLEL_CRC_CHECK_EN
    assign crc_ok    = crc_valid && crc_q == '0;
`endif
    // Out-of-range nvalid on the last beat means a full beat.
    assign n = (in_last && in_nvalid != '0 && int'(in_nvalid) <= PAR) ? int'(in_nvalid) : PAR;
    always_comb begin
        fold = crc_q;
        for (int i = 0; i < PAR; i++)
            if (i < n)
                fold = {fold[CRC_W-2:0], 1'b0} ^ ((fold[CRC_W-1] ^ in_data[PAR-1-i]) ? POLY : '0);
    end
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        case (state_q)
            IDLE, ACCUM: if (accept) begin
                crc_d   = fold;
                state_d = in_last ? DONE : ACCUM;
            end
            DONE: if (out_ready) begin
                crc_d   = INIT;
                state_d = IDLE;
            end
            default: begin
                crc_d   = INIT;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            crc_q   <= INIT;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
        end
    end
endmodule

// File: tb/tb_parallel_crc_engine.sv
// tb_parallel_crc_engine: directed and randomized frames checked against a long-division CRC model.
// Also checks crc_ok when built with PARALLEL_CRC_CHECK_EN.
module tb_parallel_crc_engine;
    localparam logic [7:0] XO = 8'h00;
    logic       clk = 0, reset = 0, in_valid = 0, in_last = 0, out_ready = 0;
    logic [2:0] in_data = '0;
    logic [1:0] in_nvalid = '0;
    logic       in_ready, crc_valid, busy;
    logic [7:0] crc_out;
`ifdef PARALLEL_CRC_CHECK_EN
    logic       crc_ok;
`endif
    int checks = 0, errors = 0;
    bit msg[$];
    parallel_crc_engine dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_nvalid(in_nvalid),
        .crc_valid(crc_valid), .crc_out(crc_out), .out_ready(out_ready),
`ifdef PARALLEL_CRC_CHECK_EN
        .crc_ok(crc_ok),
`endif
        .busy(busy)
    );
    always #5 clk = ~clk;
    // Remainder of message(x) * x^8 divided by x^8 + POLY, via long division.
    function automatic logic [7:0] model_raw();
        logic [8:0] r = '0;
        for (int k = 0; k < msg.size() + 8; k++) begin
            r = {r[7:0], (k < msg.size()) ? msg[k] : 1'b0};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic beat(input logic [2:0] d, input bit last, input int nv);
        int nb;
        @(negedge clk);
        in_valid = 1; in_data = d; in_last = last; in_nvalid = 2'(nv);
        #1;
        chk("in_ready_beat", in_ready, 1);
        chk("no_early_valid", crc_valid, 0);
        nb = (last && nv != 0) ? nv : 3;
        for (int i = 0; i < nb; i++) msg.push_back(d[2-i]);
        @(posedge clk);
        #1 in_valid = 0; in_last = 0;
    endtask
    task automatic gap(input int g);
        repeat (g) begin
            @(negedge clk);
            chk("gap_busy", busy, 1);
            chk("gap_ready", in_ready, 1);
        end
    endtask
    task automatic result(input int hold, input logic [7:0] fixed, input bit use_fixed);
        logic [7:0] raw;
        raw = model_raw();
        chk("crc_valid_lat", crc_valid, 1);
        chk("crc_out", crc_out, raw ^ XO);
        if (use_fixed) chk("crc_out_fixed", crc_out, fixed);
`ifdef PARALLEL_CRC_CHECK_EN
        chk("crc_ok", crc_ok, raw == 8'h00);
`endif
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", crc_valid, 1);
            chk("hold_out", crc_out, raw ^ XO);
            chk("hold_ready", in_ready, 0);
            chk("hold_busy", busy, 1);
        end
        @(negedge clk);
        out_ready = 1;
        #1 chk("drain_ready_low", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 0;
        chk("idle_valid", crc_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", in_ready, 1);
        msg.delete();
    endtask
    initial begin
        #2;
        chk("rst_valid", crc_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out", crc_out, 0);
        @(negedge clk) reset = 1;
        #1 chk("ready_after_rst", in_ready, 1);
        beat(3'b110, 0, 0); beat(3'b000, 0, 0); beat(3'b011, 1, 3);
        result(0, 8'h95, 1);
        beat(3'b100, 1, 1);
        result(0, 8'h07, 1);
        beat(3'b110, 0, 0); beat(3'b000, 0, 0); beat(3'b011, 0, 0);
        beat(3'b100, 0, 0); beat(3'b101, 0, 0); beat(3'b011, 1, 2);
        result(0, 8'h00, 1);
        beat(3'b110, 0, 0); beat(3'b000, 0, 0); beat(3'b011, 0, 0);
        beat(3'b101, 0, 0); beat(3'b101, 0, 0); beat(3'b011, 1, 2);
        chk("flip_nonzero", crc_out != 8'h00, 1);
        result(0, 8'h00, 0);
        beat(3'b110, 0, 0); beat(3'b000, 0, 0); beat(3'b011, 1, 3);
        result(5, 8'h95, 1);
        beat(3'b110, 0, 0); beat(3'b000, 0, 0);
        @(negedge clk) reset = 0;
        #1;
        chk("midrst_valid", crc_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 0);
        msg.delete();
        @(negedge clk) reset = 1;
        repeat (2) @(negedge clk) chk("post_rst_valid", crc_valid, 0);
        beat(3'b110, 0, 0); beat(3'b000, 0, 0); beat(3'b011, 1, 3);
        result(0, 8'h95, 1);
        beat(3'b101, 1, 2);
        @(negedge clk) reset = 0;
        #1 chk("donerst_valid", crc_valid, 0);
        msg.delete();
        @(negedge clk) reset = 1;
        repeat (2) @(negedge clk) chk("post_donerst_valid", crc_valid, 0);
        beat(3'b110, 0, 0); gap(1); beat(3'b000, 0, 0); gap(4); beat(3'b011, 1, 3);
        result(1, 8'h95, 1);
        beat(3'b110, 0, 0); gap(3); beat(3'b000, 0, 0); gap(2); beat(3'b011, 1, 3);
        result(0, 8'h95, 1);
        for (int f = 0; f < 25; f++) begin
            int nb;
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                beat(3'($urandom), b == nb - 1, (b == nb - 1) ? $urandom_range(0, 3) : $urandom_range(0, 3));
                if (b != nb - 1) gap($urandom_range(0, 2));
            end
            result($urandom_range(0, 3), 8'h00, 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
